// File: rtl/des_pkg.sv
// des_pkg: DES expansion/permutation tables, feeder FSM states and S-box latency default
package des_pkg;
  localparam int SBOX_LAT_DEF = 1;
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/des_f_sbox_feeder_if.sv
// des_f_sbox_feeder_if: operand and result handshake bundle of the f-function feeder
interface des_f_sbox_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic        out_valid;
  logic        out_ready;
  modport master (output in_valid, r_in, subkey, out_ready, input in_ready, f_out, out_valid);
  modport slave (input in_valid, r_in, subkey, out_ready, output in_ready, f_out, out_valid);
endinterface

// File: rtl/des_p_perm.sv
// des_p_perm: combinational DES P permutation, DES bit 1 on the MSB
module des_p_perm
  import des_pkg::*;
(
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  for (genvar g = 0; g < 32; g++) begin : g_p
    assign q_o[31-g] = d_i[5'(32 - P_TAB[g])];
  end
endmodule

// File: rtl/des_f_sbox_feeder.sv
// des_f_sbox_feeder: forms E(R)^K S-box addresses, waits out the external ROM latency, returns P(S)
module des_f_sbox_feeder
  import des_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  des_f_sbox_feeder_if.slave io,
  output logic [15:0]        sbox_row,
  output logic [31:0]        sbox_col,
  input  logic [31:0]        sbox_dout
);
  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [15:0] row_q, row_d;
  logic [31:0] col_q, col_d, f_q, p_out;
  logic [47:0] e, x;
  logic        out_valid_q;
  for (genvar g = 0; g < 48; g++) begin : g_e
    assign e[47-g] = io.r_in[5'(32 - E_TAB[g])];
  end
  assign x = e ^ io.subkey;
  // X is held only in split form: row {b1,b6} and col b2..b5 of each 6-bit group
  for (genvar g = 0; g < 8; g++) begin : g_addr
    assign row_d[15-2*g -: 2] = {x[47-6*g], x[42-6*g]};
    assign col_d[31-4*g -: 4] = x[46-6*g -: 4];
  end
  des_p_perm u_p_perm (.d_i(sbox_dout), .q_o(p_out));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          row_q   <= row_d;
          col_q   <= col_d;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'(SBOX_LAT)) begin
            f_q         <= p_out;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign io.in_ready  = (state_q == IDLE) && !rst;
  assign io.f_out     = f_q;
  assign io.out_valid = out_valid_q;
  assign sbox_row     = row_q;
  assign sbox_col     = col_q;
endmodule

// File: tb/tb_des_f_sbox_feeder.sv
// tb_des_f_sbox_feeder: directed vectors against FIPS 46-3 values, S-box ROMs at latency 1 and 3
module tb_des_f_sbox_feeder;
  localparam int SB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  logic        clk, rst;
  logic [15:0] row_a, row_b;
  logic [31:0] col_a, col_b, dout_a;
  logic [31:0] pipe_b [3];
  int          n_cmp = 0;
  int          n_err = 0;

  des_f_sbox_feeder_if bus_a ();
  des_f_sbox_feeder_if bus_b ();

  des_f_sbox_feeder #(.SBOX_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .io(bus_a), .sbox_row(row_a), .sbox_col(col_a), .sbox_dout(dout_a)
  );
  des_f_sbox_feeder #(.SBOX_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .io(bus_b), .sbox_row(row_b), .sbox_col(col_b), .sbox_dout(pipe_b[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sbox(input logic [15:0] row, input logic [31:0] col);
    logic [15:0] r = row;
    logic [31:0] c = col;
    logic [31:0] s = '0;
    for (int j = 0; j < 8; j++) begin
      s = {s[27:0], 4'(SB[3'(j)][{r[15:14], c[31:28]}])};
      r = r << 2;
      c = c << 4;
    end
    return s;
  endfunction

  // ROMs share the block reset, so their outputs clear in the same cycle
  always_ff @(posedge clk) dout_a <= rst ? '0 : sbox(row_a, col_a);
  always_ff @(posedge clk) begin
    pipe_b[0] <= rst ? '0 : sbox(row_b, col_b);
    pipe_b[1] <= rst ? '0 : pipe_b[0];
    pipe_b[2] <= rst ? '0 : pipe_b[1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [31:0] r, input logic [47:0] k, input logic [15:0] er,
                       input logic [31:0] ec, input logic [31:0] ef, input string tag);
    int n = 0;
    check({tag, ".in_ready"}, bus_a.in_ready, 1);
    bus_a.r_in = r;
    bus_a.subkey = k;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check({tag, ".row"}, row_a, er);
    check({tag, ".col"}, col_a, ec);
    while (!bus_a.out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 2);
    check({tag, ".f_out"}, bus_a.f_out, ef);
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    check({tag, ".drop"}, bus_a.out_valid, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.r_in = '0; bus_a.subkey = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.r_in = '0; bus_b.subkey = '0;
    repeat (2) tick();
    check("rst.in_ready", bus_a.in_ready, 0);
    check("rst.out_valid", bus_a.out_valid, 0);
    check("rst.f_out", bus_a.f_out, 0);
    check("rst.row", row_a, 0);
    check("rst.col", col_a, 0);
    rst = 1'b0;
    #1;
    check("idle.in_ready", bus_a.in_ready, 1);

    run_a(32'h0, 48'h0, 16'h0000, 32'h0000_0000, 32'hD8D8_DBBC, "zero");
    run_a(32'h0, 48'hFFFF_FFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'h38DB_F9CB, "ones");
    run_a(32'hF0AA_F0AA, 48'h1B02_EFFC_7072, 16'h12E3, 32'hC8FD_03A3, 32'h234A_A9BB, "fips");

    // back-pressure with in_valid kept busy and r_in changing
    bus_a.r_in = 32'hF0AA_F0AA; bus_a.subkey = 48'h1B02_EFFC_7072; bus_a.in_valid = 1'b1;
    tick();
    bus_a.r_in = '0; bus_a.subkey = '0;
    repeat (2) tick();
    check("stall.valid", bus_a.out_valid, 1);
    check("stall.f_out", bus_a.f_out, 32'h234A_A9BB);
    for (int i = 0; i < 10; i++) begin
      bus_a.in_valid = i[0];
      bus_a.r_in = 32'h1357_9BDF ^ 32'(i);
      tick();
      check("stall.f_hold", bus_a.f_out, 32'h234A_A9BB);
      check("stall.valid_hold", bus_a.out_valid, 1);
      check("stall.in_ready", bus_a.in_ready, 0);
      check("stall.row", row_a, 16'h12E3);
    end
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    check("stall.release", bus_a.out_valid, 0);
    repeat (3) tick();
    check("stall.no_second", bus_a.out_valid, 0);
    check("stall.row_kept", row_a, 16'h12E3);

    // reset while waiting on the ROM
    bus_a.r_in = '0; bus_a.subkey = 48'hFFFF_FFFF_FFFF; bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_wait.out_valid", bus_a.out_valid, 0);
    check("rst_wait.f_out", bus_a.f_out, 0);
    check("rst_wait.row", row_a, 0);
    rst = 1'b0;
    #1;
    check("rst_wait.in_ready", bus_a.in_ready, 1);
    repeat (3) tick();
    check("rst_wait.no_result", bus_a.out_valid, 0);

    // reset while holding a result
    bus_a.r_in = 32'hF0AA_F0AA; bus_a.subkey = 48'h1B02_EFFC_7072; bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    repeat (2) tick();
    check("rst_done.pre_valid", bus_a.out_valid, 1);
    rst = 1'b1;
    tick();
    check("rst_done.out_valid", bus_a.out_valid, 0);
    check("rst_done.f_out", bus_a.f_out, 0);
    check("rst_done.col", col_a, 0);
    rst = 1'b0;
    #1;
    check("rst_done.in_ready", bus_a.in_ready, 1);
    run_a(32'h0, 48'hFFFF_FFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'h38DB_F9CB, "post_rst");

    // three-cycle ROM latency
    check("lat3.in_ready", bus_b.in_ready, 1);
    bus_b.r_in = 32'hF0AA_F0AA; bus_b.subkey = 48'h1B02_EFFC_7072; bus_b.in_valid = 1'b1;
    tick();
    bus_b.in_valid = 1'b0;
    n = 0;
    while (!bus_b.out_valid && n < 12) begin
      tick();
      n++;
    end
    check("lat3.latency", n, 4);
    check("lat3.f_out", bus_b.f_out, 32'h234A_A9BB);
    check("lat3.row", row_b, 16'h12E3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
